vga_fb_arbiter: RTL
===================

Name: vga_fb_arbiter

Overview:
- Shares one single-port pixel frame-buffer RAM between two requesters.
- Requester 1 is the display line prefetcher: it copies the next scanline into a line buffer during the line period.
- Requester 2 is a drawing/host writer using a req/ack handshake.
- Sits between vga_sync (line timing) and the frame-buffer RAM; vga_display reads the line buffer.

Parameters:
- ADDR_W, 19, frame-buffer word address width.
- DATA_W, 24, pixel word width (8:8:8 RGB).
- H_ACTIVE, 640, pixels fetched per line.
- V_ACTIVE, 480, valid line indices 0..V_ACTIVE-1.
- RD_LAT, 2, RAM read latency in cycles, from mem_addr registered to mem_rdata valid; minimum 1.
- MAX_WAIT, 16, cycles a pending write may be stalled during a fetch before it is forced in.

Ports:
- clk  in  1  pixel clock.
- rst  in  1  reset, asynchronous, active-low.
- line_req  in  1  one-cycle pulse: fetch line line_y.
- line_y  in  12  line index to fetch.
- line_done  out  1  one-cycle pulse: last pixel written to line buffer.
- err_overrun  out  1  sticky: line_req arrived while busy.
- wr_req  in  1  writer request; held until ack.
- wr_addr  in  ADDR_W  writer address; stable while wr_req.
- wr_data  in  DATA_W  writer data; stable while wr_req.
- wr_ack  out  1  one-cycle pulse: write performed.
- mem_addr  out  ADDR_W  RAM address (registered).
- mem_we  out  1  RAM write enable (registered).
- mem_wdata  out  DATA_W  RAM write data (registered).
- mem_rdata  in  DATA_W  RAM read data, RD_LAT after the address.
- lb_we  out  1  line-buffer write enable.
- lb_addr  out  10  line-buffer address 0..H_ACTIVE-1.
- lb_wdata  out  DATA_W  line-buffer data.

Behaviour:
- Reset (rst=0, asynchronous):
  - All outputs 0; state IDLE; counters 0.
  - Read pipeline flushed, so no lb_we follows reset, including reset mid-fetch.
- States:
  - IDLE -> FETCH on line_req with line_y<V_ACTIVE. On entry, latch base=line_y*H_ACTIVE and set rd_idx=0.
  - FETCH -> DRAIN in the cycle the read with rd_idx=H_ACTIVE-1 is issued.
  - DRAIN: wait RD_LAT cycles for returns, then pulse line_done for one cycle -> IDLE.
- Ignored requests:
  - line_req with line_y>=V_ACTIVE is ignored in every state.
  - line_req in FETCH or DRAIN is ignored and sets err_overrun, which stays set until reset.
- Slot decision each cycle; effect is registered and visible on mem_* the next cycle:
  - IDLE or DRAIN: grant writer if wr_req.
  - FETCH: issue read base+rd_idx, rd_idx++; except when wr_req and wait_cnt==MAX_WAIT, then grant writer and do not advance rd_idx.
- Writer:
  - wr_ack is asserted in the same cycle mem_we=1 (one cycle after the decision).
  - The writer must hold its request and not re-present it in the ack cycle; the arbiter never grants the same request twice.
- wait_cnt (saturating at MAX_WAIT):
  - Increments each cycle wr_req=1 with no grant.
  - Clears on grant.
- Read returns: a valid/index shift register RD_LAT deep. When mem_rdata is valid, lb_we=1, lb_addr=index, lb_wdata=mem_rdata, all in the same cycle.
- Fetch latency: minimum H_ACTIVE+RD_LAT+2 cycles from line_req to line_done; each forced write adds 1 cycle.
- Address arithmetic: ADDR_W-bit, no wrap expected. line_y*H_ACTIVE is computed once per line, registered.

Optional Feature:
- Macro VGA_ARB_PERF_EN.
- Defined: adds output perf_max_wait (16 bits), the largest wait_cnt observed before any grant. It is cleared by reset only and saturates at 16'hFFFF.
- Undefined: port and logic absent; behaviour otherwise identical.

Decomposition:
- Package vga_arb_pkg:
  - State enum {IDLE, FETCH, DRAIN}.
  - Default parameter constants.
  - Line-buffer address width constant.
- Sub-module vga_rd_pipe: RD_LAT-deep valid+index delay line with async active-low clear. It produces lb_we/lb_addr and is reusable by other fetch engines.

Test Plan (H_ACTIVE=8, RD_LAT=2, MAX_WAIT=3 unless noted):
- line_req, line_y=2, no writer -> mem_addr 16..23 on consecutive cycles, mem_we=0; lb_addr 0..7 match the rdata model; line_done exactly 12 cycles after line_req.
- IDLE, wr_req addr=5 data=24'hABCDEF -> next cycle mem_we=1, mem_addr=5, mem_wdata=ABCDEF, wr_ack=1; single ack only.
- line_req line_y=0 with wr_req high throughout fetch -> write forced after 3 stall cycles; reads resume at the next rd_idx; all 8 lb writes correct; line_done delayed by 1.
- line_req during FETCH -> ignored, err_overrun=1 and stays 1; line_y=480 in IDLE -> no fetch, no flag.
- rst low during FETCH at rd_idx=4 -> immediately all outputs 0, no lb_we afterwards; a new line_req after release fetches cleanly.
- VGA_ARB_PERF_EN defined, forced-write scenario -> perf_max_wait=3.

Source files
------------

// File: rtl/vga_arb_pkg.sv
// Shared types and default constants for the frame-buffer arbiter.
// Imported by the arbiter top and its read-return pipe.
package vga_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DRAIN
    } arb_state_t;

    localparam int DEF_ADDR_W   = 19;
    localparam int DEF_DATA_W   = 24;
    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_RD_LAT   = 2;
    localparam int DEF_MAX_WAIT = 16;

    localparam int LB_AW  = 10;
    localparam int LINE_W = 12;
    localparam int PERF_W = 16;

    // Clamp a wide count into the 16-bit perf counter range.
    function automatic logic [PERF_W-1:0] sat16(input logic [31:0] v);
        logic [PERF_W-1:0] r;
        r = (v > 32'h0000_FFFF) ? 16'hFFFF : v[PERF_W-1:0];
        return r;
    endfunction

endpackage

// File: rtl/vga_rd_pipe.sv
// Valid/index delay line matching the RAM read latency.
// Its output drives the line-buffer write port directly.
module vga_rd_pipe #(
    parameter int RD_LAT = 2,
    parameter int IDX_W  = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_vld,
    input  logic [IDX_W-1:0] in_idx,
    output logic             out_vld,
    output logic [IDX_W-1:0] out_idx
);

    logic [RD_LAT-1:0] vld;
    logic [IDX_W-1:0]  idx [RD_LAT];

    // Shift issued reads along so they line up with returning data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                idx[i] <= '0;
            end
        end else begin
            vld[0] <= in_vld;
            idx[0] <= in_idx;
            for (int i = 1; i < RD_LAT; i++) begin
                vld[i] <= vld[i-1];
                idx[i] <= idx[i-1];
            end
        end
    end

    assign out_vld = vld[RD_LAT-1];
    assign out_idx = idx[RD_LAT-1];

endmodule

// File: rtl/vga_fb_arbiter.sv
// Frame-buffer slot arbiter: scanline prefetch vs. host writer.
// Optional VGA_ARB_PERF_EN adds the perf_max_wait stall monitor.
module vga_fb_arbiter
    import vga_arb_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int RD_LAT   = DEF_RD_LAT,
    parameter int MAX_WAIT = DEF_MAX_WAIT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              line_req,
    input  logic [LINE_W-1:0] line_y,
    output logic              line_done,
    output logic              err_overrun,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ack,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              lb_we,
    output logic [LB_AW-1:0]  lb_addr,
    output logic [DATA_W-1:0] lb_wdata
`ifdef VGA_ARB_PERF_EN
    ,
    output logic [PERF_W-1:0] perf_max_wait
`endif
);

    localparam int WC_W = $clog2(MAX_WAIT + 2);
    localparam int DC_W = $clog2(RD_LAT + 2);

    localparam logic [WC_W-1:0] WC_MAX = WC_W'(MAX_WAIT);
    localparam logic [DC_W-1:0] DC_MAX = DC_W'(RD_LAT);
    localparam logic [LB_AW-1:0] IDX_LAST = LB_AW'(H_ACTIVE - 1);

    arb_state_t state;
    arb_state_t state_nx;

    logic [ADDR_W-1:0] base;
    logic [LB_AW-1:0]  rd_idx;
    logic [LB_AW-1:0]  ridx_q;
    logic              rd_q;
    logic [DC_W-1:0]   drain_cnt;
    logic [WC_W-1:0]   wait_cnt;

    logic req_ok;
    logic wr_pend;
    logic last_rd;
    logic rd_go;
    logic wr_go;

    // A request in its ack cycle is already served.
    assign req_ok  = line_req && (32'(line_y) < V_ACTIVE);
    assign wr_pend = wr_req && !wr_ack;
    assign last_rd = (rd_idx == IDX_LAST);

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end

    // Next-state: fetch a line, then drain the read returns.
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (req_ok) state_nx = FETCH;
            FETCH:   if (rd_go && last_rd) state_nx = DRAIN;
            DRAIN:   if (drain_cnt == DC_MAX) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Slot decision: reads own FETCH unless the writer starved.
    always_comb begin
        rd_go = 1'b0;
        wr_go = 1'b0;
        unique case (state)
            IDLE:  wr_go = wr_pend;
            DRAIN: wr_go = wr_pend;
            FETCH: begin
                if (wr_pend && wait_cnt == WC_MAX) wr_go = 1'b1;
                else                               rd_go = 1'b1;
            end
            default: ;
        endcase
    end

    // Register the granted RAM access and the writer ack.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_addr  <= '0;
            mem_we    <= 1'b0;
            mem_wdata <= '0;
            wr_ack    <= 1'b0;
            rd_q      <= 1'b0;
            ridx_q    <= '0;
        end else begin
            mem_we <= wr_go;
            wr_ack <= wr_go;
            rd_q   <= rd_go;
            if (wr_go) begin
                mem_addr  <= wr_addr;
                mem_wdata <= wr_data;
            end else if (rd_go) begin
                mem_addr <= base + ADDR_W'(rd_idx);
                ridx_q   <= rd_idx;
            end
        end
    end

    // Line base, read index and drain timer.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            base      <= '0;
            rd_idx    <= '0;
            drain_cnt <= '0;
        end else begin
            if (state == IDLE && req_ok) begin
                base   <= ADDR_W'(line_y) * ADDR_W'(H_ACTIVE);
                rd_idx <= '0;
            end else if (rd_go) begin
                rd_idx <= rd_idx + 1'b1;
            end
            if (state == DRAIN) drain_cnt <= drain_cnt + 1'b1;
            else                drain_cnt <= '0;
        end
    end

    // Writer starvation counter, saturating.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wait_cnt <= '0;
        end else if (wr_go) begin
            wait_cnt <= '0;
        end else if (wr_pend && wait_cnt != WC_MAX) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    // Done pulse and sticky overrun flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            line_done   <= 1'b0;
            err_overrun <= 1'b0;
        end else begin
            line_done <= (state == DRAIN) && (drain_cnt == DC_MAX);
            if (req_ok && state != IDLE) err_overrun <= 1'b1;
        end
    end

`ifdef VGA_ARB_PERF_EN
    // Track the longest stall seen by any granted write.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_max_wait <= '0;
        end else if (wr_go) begin
            if (sat16(32'(wait_cnt)) > perf_max_wait)
                perf_max_wait <= sat16(32'(wait_cnt));
        end
    end
`endif

    vga_rd_pipe #(
        .RD_LAT (RD_LAT),
        .IDX_W  (LB_AW)
    ) u_rd_pipe (
        .clk     (clk),
        .rst_n   (rst),
        .in_vld  (rd_q),
        .in_idx  (ridx_q),
        .out_vld (lb_we),
        .out_idx (lb_addr)
    );

    assign lb_wdata = lb_we ? mem_rdata : '0;

endmodule
